// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle arithmetic/logic ops, bit-serial
// shifts and an optional iterative shift-add multiplier.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst_n    - asynchronous active-low reset
//   start    - request, sampled only while idle (busy=0)
//   OpCode   - operation select (ADD..MUL = 0..11, 12..31 illegal)
//   Rsrc     - source operand; low SHAMT_W bits are the shift amount
//   Rdest    - destination operand; the value shifted by shift ops
//   Out      - registered result
//   Flags    - registered flags {N, Z, F, L, C}
//   busy     - high while a multi-cycle operation is in flight
//   done     - one-cycle pulse when Out/Flags are updated
//   illegal  - qualifies done for an unsupported opcode
//
// Build option: define ALU_MUL_EN to include the MUL opcode; otherwise
// opcode 11 is treated as illegal and the multiplier is not built.
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       OpCode,
    input  logic [WIDTH-1:0] Rsrc,
    input  logic [WIDTH-1:0] Rdest,
    output logic [WIDTH-1:0] Out,
    output logic [4:0]       Flags,
    output logic             busy,
    output logic             done,
    output logic             illegal
);
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_CMP  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_NOT  = 5'd6;
    localparam logic [4:0] OP_LSH  = 5'd7;
    localparam logic [4:0] OP_RSH  = 5'd8;
    localparam logic [4:0] OP_ARSH = 5'd9;
    localparam logic [4:0] OP_ADDC = 5'd10;

`ifdef ALU_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'd11;
    typedef enum logic [1:0] {IDLE, SHIFT, MULT} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t             state, state_n;
    logic [4:0]         op_q, op_n;
    logic [WIDTH-1:0]   a_q, a_n, b_q, b_n, out_n;
    logic [SHAMT_W-1:0] cnt_q, cnt_n;
    logic [4:0]         flags_n, arith_flags;
    logic               pend_q, pend_n, done_n, ill_n;
    logic               is_sub, is_arith, is_shift, legal, cin;
    logic [WIDTH-1:0]   b_op, res, shifted;
    logic [WIDTH:0]     sum;

    // One adder serves ADD/ADDC/SUB/CMP; subtraction is a + ~b + 1.
    assign is_sub   = op_q == OP_SUB || op_q == OP_CMP;
    assign is_arith = op_q inside {OP_ADD, OP_SUB, OP_CMP, OP_ADDC};
    assign is_shift = op_q inside {OP_LSH, OP_RSH, OP_ARSH};
    assign legal    = op_q <= OP_ADDC;
    assign b_op     = is_sub ? ~b_q : b_q;
    assign cin      = is_sub ? 1'b1 : (op_q == OP_ADDC) & Flags[0];
    assign sum      = {1'b0, a_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    // Overflow: both adder inputs share a sign that the result does not.
    assign arith_flags = {$signed(a_q) < $signed(b_q), sum[WIDTH-1:0] == '0,
                          (a_q[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]),
                          a_q < b_q, sum[WIDTH]};
    assign res = op_q == OP_AND ? a_q & b_q :
                 op_q == OP_OR  ? a_q | b_q :
                 op_q == OP_XOR ? a_q ^ b_q :
                 op_q == OP_NOT ? ~b_q : sum[WIDTH-1:0];
    assign shifted = op_q == OP_LSH ? a_q << 1
                                    : {(op_q == OP_ARSH) & a_q[WIDTH-1], a_q[WIDTH-1:1]};
    assign busy = state != IDLE;

`ifdef ALU_MUL_EN
    // Product register is {hi_q, b_q}: the multiplier drains out of b_q's
    // LSB while product bits shift in at its MSB.
    logic [WIDTH-1:0] hi_q, hi_n;
    logic [WIDTH:0]   mac;
    assign mac = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : '0);
`endif

    always_comb begin
        state_n = state;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        cnt_n   = cnt_q;
        pend_n  = 1'b0;
        out_n   = Out;
        flags_n = Flags;
        done_n  = 1'b0;
        ill_n   = 1'b0;
`ifdef ALU_MUL_EN
        hi_n    = hi_q;
`endif
        if (state == SHIFT) begin
            if (cnt_q == '0) begin
                state_n = IDLE;
                out_n   = a_q;
                done_n  = 1'b1;
            end else begin
                a_n   = shifted;
                cnt_n = cnt_q - SHAMT_W'(1);
            end
        end
`ifdef ALU_MUL_EN
        else if (state == MULT) begin
            if (cnt_q == '0) begin
                state_n = IDLE;
                out_n   = b_q;
                flags_n = {Flags[4], b_q == '0, Flags[2:1], |hi_q};
                done_n  = 1'b1;
            end else begin
                {hi_n, b_n} = {mac, b_q[WIDTH-1:1]};
                cnt_n       = cnt_q - SHAMT_W'(1);
            end
        end
`endif
        else if (pend_q) begin
            // First execution edge after the request was latched.
            if (is_shift) begin
                if (b_q[SHAMT_W-1:0] == '0) begin
                    out_n  = a_q;
                    done_n = 1'b1;
                end else begin
                    state_n = SHIFT;
                    a_n     = shifted;
                    cnt_n   = b_q[SHAMT_W-1:0] - SHAMT_W'(1);
                end
            end
`ifdef ALU_MUL_EN
            else if (op_q == OP_MUL) begin
                state_n     = MULT;
                {hi_n, b_n} = {mac, b_q[WIDTH-1:1]};
                cnt_n       = SHAMT_W'(WIDTH - 1);
            end
`endif
            else begin
                done_n = 1'b1;
                ill_n  = !legal;
                if (legal && op_q != OP_CMP) out_n = res;
                if (legal && is_arith) flags_n = arith_flags;
            end
        end
        // A request arriving on the edge that launches a multi-cycle op is
        // dropped, as the unit is about to go busy.
        if (start && state == IDLE && state_n == IDLE) begin
            op_n   = OpCode;
            a_n    = Rdest;
            b_n    = Rsrc;
            pend_n = 1'b1;
`ifdef ALU_MUL_EN
            hi_n   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            Out     <= '0;
            Flags   <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
`ifdef ALU_MUL_EN
            hi_q    <= '0;
`endif
        end else begin
            state   <= state_n;
            op_q    <= op_n;
            a_q     <= a_n;
            b_q     <= b_n;
            cnt_q   <= cnt_n;
            pend_q  <= pend_n;
            Out     <= out_n;
            Flags   <= flags_n;
            done    <= done_n;
            illegal <= ill_n;
`ifdef ALU_MUL_EN
            hi_q    <= hi_n;
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=16) using a vector table,
// hand-written multi-cycle sequences and a randomized reference model.
module tb_alu_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [4:0]  OpCode = '0;
    logic [15:0] Rsrc = '0, Rdest = '0;
    logic [15:0] Out;
    logic [4:0]  Flags;
    logic        busy, done, illegal;

    int total = 0, passed = 0;
    logic [15:0] m_out = '0;
    logic [4:0]  m_flags = '0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .OpCode(OpCode),
        .Rsrc(Rsrc), .Rdest(Rdest), .Out(Out), .Flags(Flags),
        .busy(busy), .done(done), .illegal(illegal)
    );

    typedef struct {
        logic [4:0]  op;
        logic [15:0] d, s, eo;
        logic [4:0]  ef;
        logic        ei;
        int          el;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [4:0] op, input logic [15:0] d, s, eo,
                                input logic [4:0] ef, input logic ei, input int el);
        vec_t v;
        v.op = op; v.d = d; v.s = s; v.eo = eo; v.ef = ef; v.ei = ei; v.el = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Issue one request and wait for its done; lat = index k of edge E(k).
    task automatic run_op(input logic [4:0] op, input logic [15:0] d, s,
                          output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; OpCode = op; Rdest = d; Rsrc = s;
        @(posedge clk);
        #1;
        start = 1'b0; OpCode = 5'($urandom); Rdest = 16'($urandom); Rsrc = 16'($urandom);
        lat = 0; bcnt = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end while (!done && lat < 40);
    endtask

    // Reference model: results derived from the operation definitions.
    task automatic ref_op(input logic [4:0] op, input logic [15:0] d, s,
                          output logic [15:0] eo, output logic [4:0] ef,
                          output logic ei, output int el);
        int sd, ss, sr, u, n, ci;
        logic c;
        logic [15:0] r;
        logic signed [15:0] ds;
        longint unsigned p;
        sd = int'($signed(d)); ss = int'($signed(s)); n = int'(s[3:0]); ds = d;
        eo = m_out; ef = m_flags; ei = 1'b0; el = 1;
        case (op)
            5'd0, 5'd1, 5'd2, 5'd10: begin
                ci = op == 5'd10 ? int'(m_flags[0]) : 0;
                if (op == 5'd1 || op == 5'd2) begin
                    u = int'(d) - int'(s); sr = sd - ss; c = d >= s;
                end else begin
                    u = int'(d) + int'(s) + ci; sr = sd + ss + ci; c = u > 65535;
                end
                r = 16'(u);
                ef = {sd < ss, r == 16'd0, sr > 32767 || sr < -32768, d < s, c};
                if (op != 5'd2) eo = r;
            end
            5'd3: eo = d & s;
            5'd4: eo = d | s;
            5'd5: eo = d ^ s;
            5'd6: eo = ~s;
            5'd7: begin eo = d << n; el = n + 1; end
            5'd8: begin eo = d >> n; el = n + 1; end
            5'd9: begin eo = ds >>> n; el = n + 1; end
            5'd11: begin
`ifdef ALU_MUL_EN
                p = longint'(d) * longint'(s);
                eo = p[15:0]; ef[0] = p[31:16] != 0; ef[3] = eo == 16'd0; el = 17;
`else
                ei = 1'b1;
`endif
            end
            default: ei = 1'b1;
        endcase
        m_out = eo; m_flags = ef;
    endtask

    task automatic check_op(input string name, input logic [15:0] eo, input logic [4:0] ef,
                            input logic ei, input int el, input int lat, input int bcnt);
        chk({name, " out"}, Out, eo);
        chk({name, " flags"}, Flags, ef);
        chk({name, " illegal"}, illegal, ei);
        chk({name, " done edge"}, lat, el);
        chk({name, " busy cycles"}, bcnt, el - 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal;
    end

    initial begin
        int lat, bcnt, el;
        logic [4:0] op, ef;
        logic [15:0] d, s, eo;
        logic ei, saw_done;

        repeat (3) @(negedge clk);
        chk("reset Out", Out, 0);
        chk("reset Flags", Flags, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset illegal", illegal, 0);
        rst_n = 1'b1;

        // Flags are {N, Z, F, L, C}; rows run in order, so each row starts from
        // the Out/Flags the previous row left behind.
        tbl.push_back(mk(5'd0,  16'h7FFF, 16'h0001, 16'h8000, 5'b00100, 1'b0, 1));
        tbl.push_back(mk(5'd9,  16'h8004, 16'h0003, 16'hF000, 5'b00100, 1'b0, 4));
        tbl.push_back(mk(5'd1,  16'h0005, 16'h0005, 16'h0000, 5'b01001, 1'b0, 1));
        tbl.push_back(mk(5'd3,  16'hF0F0, 16'h0FF0, 16'h00F0, 5'b01001, 1'b0, 1));
        tbl.push_back(mk(5'd4,  16'h1200, 16'h0034, 16'h1234, 5'b01001, 1'b0, 1));
        tbl.push_back(mk(5'd5,  16'hFFFF, 16'h1234, 16'hEDCB, 5'b01001, 1'b0, 1));
        tbl.push_back(mk(5'd6,  16'hAAAA, 16'h00FF, 16'hFF00, 5'b01001, 1'b0, 1));
        tbl.push_back(mk(5'd2,  16'h0003, 16'h0005, 16'hFF00, 5'b10010, 1'b0, 1));
        tbl.push_back(mk(5'd20, 16'h1111, 16'h2222, 16'hFF00, 5'b10010, 1'b1, 1));
        tbl.push_back(mk(5'd7,  16'h0001, 16'h0000, 16'h0001, 5'b10010, 1'b0, 1));
        tbl.push_back(mk(5'd8,  16'h8000, 16'h000F, 16'h0001, 5'b10010, 1'b0, 16));
        tbl.push_back(mk(5'd7,  16'h0003, 16'h0004, 16'h0030, 5'b10010, 1'b0, 5));
`ifdef ALU_MUL_EN
        tbl.push_back(mk(5'd11, 16'h0100, 16'h0100, 16'h0000, 5'b11011, 1'b0, 17));
`else
        tbl.push_back(mk(5'd11, 16'h0100, 16'h0100, 16'h0030, 5'b10010, 1'b1, 1));
`endif
        tbl.push_back(mk(5'd0,  16'h8000, 16'h8000, 16'h0000, 5'b01101, 1'b0, 1));
        tbl.push_back(mk(5'd10, 16'h0001, 16'h0001, 16'h0003, 5'b00000, 1'b0, 1));
        tbl.push_back(mk(5'd31, 16'h0001, 16'h0001, 16'h0003, 5'b00000, 1'b1, 1));
        tbl.push_back(mk(5'd12, 16'h0001, 16'h0001, 16'h0003, 5'b00000, 1'b1, 1));

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].d, tbl[i].s, lat, bcnt);
            check_op($sformatf("vec%0d op%0d", i, tbl[i].op), tbl[i].eo, tbl[i].ef,
                     tbl[i].ei, tbl[i].el, lat, bcnt);
        end

        // Back-to-back: SUB then ADDC with start held, ADDC sees SUB's carry.
        @(negedge clk);
        start = 1'b1; OpCode = 5'd1; Rdest = 16'h0005; Rsrc = 16'h0005;
        @(posedge clk);
        #1;
        OpCode = 5'd10; Rdest = 16'h0001; Rsrc = 16'h0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b sub done", done, 1);
        chk("b2b sub out", Out, 16'h0000);
        chk("b2b sub Z", Flags[3], 1);
        chk("b2b sub C", Flags[0], 1);
        @(posedge clk);
        #1;
        chk("b2b addc done", done, 1);
        chk("b2b addc out", Out, 16'h0003);
        @(posedge clk);
        #1;
        chk("b2b done pulse width", done, 0);

        // LSH by 15, a start while busy, then reset at E5 aborts the shift.
        @(negedge clk);
        start = 1'b1; OpCode = 5'd7; Rdest = 16'hABCD; Rsrc = 16'h000F;
        @(posedge clk);
        #1;
        start = 1'b0;
        saw_done = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
            if (k == 2) begin start = 1'b1; OpCode = 5'd0; Rdest = 16'h0001; Rsrc = 16'h0001; end
            if (k == 3) start = 1'b0;
        end
        chk("abort busy before reset", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort Out", Out, 0);
        chk("abort Flags", Flags, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort no done", saw_done, 0);
        chk("abort busy idle", busy, 0);

        m_out = '0; m_flags = '0;
        for (int i = 0; i < 150; i++) begin
            op = 5'($urandom_range(0, 13));
            if ($urandom_range(0, 15) == 0) op = 5'($urandom_range(12, 31));
            d = 16'($urandom); s = 16'($urandom);
            if ($urandom_range(0, 3) == 0) s = d;
            ref_op(op, d, s, eo, ef, ei, el);
            run_op(op, d, s, lat, bcnt);
            check_op($sformatf("rnd%0d op%0d d=%h s=%h", i, op, d, s), eo, ef, ei, el, lat, bcnt);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
